flu_wb_scheduler: RTL

//  Issue scheduler for the fixed-latency unit (FLU) writeback port shared by ALU, branch, CSR, MUL and DIV.

---
 rtl/flu_wb_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/flu_wb_scheduler.sv
// rtl/flu_wb_scheduler.sv - issue scheduler and writeback select for the shared FLU write port
module flu_wb_scheduler #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned MUL_LAT       = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic [2:0]               issue_fu_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    output logic                     issue_ready_o,
    input  logic                     div_done_i,
    output logic                     wb_valid_o,
    output logic [2:0]               wb_src_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam logic [2:0] FU_ALU    = 3'd0;
    localparam logic [2:0] FU_BRANCH = 3'd1;
    localparam logic [2:0] FU_CSR    = 3'd2;
    localparam logic [2:0] FU_MUL    = 3'd3;
    localparam logic [2:0] FU_DIV    = 3'd4;

    localparam int unsigned TID_W = MUL_LAT * TRANS_ID_BITS;

    // Slot k (1..MUL_LAT) of tid_q lives at bits [(k-1)*TRANS_ID_BITS +: TRANS_ID_BITS].
    logic [MUL_LAT:1]           resv_q;
    logic [MUL_LAT:1]           resv_shift;
    logic [MUL_LAT:1]           resv_next;
    logic [TID_W-1:0]           tid_q;
    logic [TID_W-1:0]           tid_next;
    logic                       div_busy_q;
    logic [TRANS_ID_BITS-1:0]   div_tid_q;
    logic                       err_q;
    logic [CNT_W-1:0]           stall_q;

    logic fast_fu;
    logic fire;
    logic fast_fire;
    logic mul_fire;
    logic div_fire;
    logic div_done_ok;
    logic stall_evt;

    assign resv_shift = resv_q >> 1;
    assign fast_fu    = (issue_fu_i == FU_ALU) || (issue_fu_i == FU_BRANCH) ||
                        (issue_fu_i == FU_CSR);

    always_comb begin
        issue_ready_o = 1'b0;
        case (issue_fu_i)
            FU_ALU, FU_BRANCH, FU_CSR: issue_ready_o = !div_busy_q && !resv_q[1];
            FU_MUL:                    issue_ready_o = !div_busy_q && !resv_shift[MUL_LAT];
            // A divide waits for a drained pipeline so its done pulse never meets a MUL result.
            FU_DIV:                    issue_ready_o = !div_busy_q && (resv_q == '0);
            default:                   issue_ready_o = 1'b0;
        endcase
    end

    assign fire        = issue_valid_i && issue_ready_o && !flush_i;
    assign fast_fire   = fire && fast_fu;
    assign mul_fire    = fire && (issue_fu_i == FU_MUL);
    assign div_fire    = fire && (issue_fu_i == FU_DIV);
    assign div_done_ok = div_done_i && div_busy_q;
    assign stall_evt   = issue_valid_i && !issue_ready_o && !flush_i;

    always_comb begin
        resv_next          = resv_shift;
        resv_next[MUL_LAT] = mul_fire;
        tid_next           = tid_q >> TRANS_ID_BITS;
        tid_next[(MUL_LAT-1)*TRANS_ID_BITS +: TRANS_ID_BITS] =
            mul_fire ? issue_trans_id_i : '0;
    end

    always_comb begin
        wb_valid_o    = 1'b0;
        wb_src_o      = 3'd0;
        wb_trans_id_o = '0;
        if (!flush_i) begin
            if (div_done_ok) begin
                wb_valid_o    = 1'b1;
                wb_src_o      = FU_DIV;
                wb_trans_id_o = div_tid_q;
            end else if (resv_q[1]) begin
                wb_valid_o    = 1'b1;
                wb_src_o      = FU_MUL;
                wb_trans_id_o = tid_q[TRANS_ID_BITS-1:0];
            end else if (fast_fire) begin
                wb_valid_o    = 1'b1;
                wb_src_o      = issue_fu_i;
                wb_trans_id_o = issue_trans_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resv_q     <= '0;
            tid_q      <= '0;
            div_busy_q <= 1'b0;
            div_tid_q  <= '0;
        end else if (flush_i) begin
            resv_q     <= '0;
            tid_q      <= '0;
            div_busy_q <= 1'b0;
        end else begin
            resv_q <= resv_next;
            tid_q  <= tid_next;
            if (div_fire) begin
                div_busy_q <= 1'b1;
                div_tid_q  <= issue_trans_id_i;
            end else if (div_done_ok) begin
                div_busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            if (div_done_i && !div_busy_q) begin
                err_q <= 1'b1;
            end
            if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign busy_o      = div_busy_q || (resv_q != '0);
    assign err_o       = err_q;
    assign stall_cnt_o = stall_q;

endmodule
